// File: rtl/mul_div_unit.sv
// Iterative RV64M/RV32M multiply/divide unit: one shift-add or restoring-divide bit per cycle.
// Result is held in DONE until the consumer handshakes; flush aborts any in-flight operation.
module mul_div_unit #(
    parameter int unsigned XLEN        = 64,
    parameter bit          ENABLE_WORD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW      = $clog2(XLEN + 1);
    localparam int unsigned PW      = 2 * XLEN;
    localparam bit          WORD_OK = ENABLE_WORD && (XLEN == 64);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   in_ready_nx, busy_nx, out_valid_nx;

    // Operand decode on the request inputs
    logic            word_c, is_div, sgn1, sgn2;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, dividend_res, special_res;
    logic            a_neg, b_neg, div_zero, div_ovf, special, accept_c;

    // Latched operation and iteration state
    logic [2:0]      op_q;
    logic            word_q, a_neg_q, b_neg_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0] mplr_q, rem_q, quo_q, dvsr_q;

    logic [XLEN:0]   trial;
    logic            div_bit;
    logic [XLEN-1:0] rem_nx;
    logic [PW-1:0]   prod_s;
    logic [XLEN-1:0] quo_s, rem_s, sel, fix_res;

    always_comb begin
        word_c   = WORD_OK && word;
        is_div   = op[2];
        sgn1     = is_div ? !op[0] : (!word_c && (op[1:0] == 2'b01 || op[1:0] == 2'b10));
        sgn2     = is_div ? !op[0] : (!word_c && (op[1:0] == 2'b01));
        if (word_c) begin
            a_ext = sgn1 ? XLEN'($signed(op1[31:0])) : XLEN'(op1[31:0]);
            b_ext = sgn2 ? XLEN'($signed(op2[31:0])) : XLEN'(op2[31:0]);
        end else begin
            a_ext = op1;
            b_ext = op2;
        end
        a_neg    = sgn1 && a_ext[XLEN-1];
        b_neg    = sgn2 && b_ext[XLEN-1];
        abs_a    = a_neg ? -a_ext : a_ext;
        abs_b    = b_neg ? -b_ext : b_ext;
        div_zero = is_div && (b_ext == '0);
        if (word_c)
            div_ovf = is_div && !op[0] && (op1[31:0] == 32'h8000_0000) && (op2[31:0] == 32'hFFFF_FFFF);
        else
            div_ovf = is_div && !op[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
        special      = div_zero || div_ovf;
        dividend_res = word_c ? XLEN'($signed(op1[31:0])) : op1;
        // Zero divisor: quotient all ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
        if (div_zero)
            special_res = op[1] ? dividend_res : {XLEN{1'b1}};
        else
            special_res = op[1] ? '0 : dividend_res;
        accept_c = in_valid && in_ready && !flush;
    end

    // One restoring-divide step on the magnitudes
    always_comb begin
        trial   = {rem_q, quo_q[XLEN-1]};
        div_bit = trial >= {1'b0, dvsr_q};
        rem_nx  = XLEN'(div_bit ? (trial - {1'b0, dvsr_q}) : trial);
    end

    // Sign correction and result selection
    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo_s  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        rem_s  = a_neg_q ? -rem_q : rem_q;
        if (op_q[2])
            sel = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00 || word_q)
            sel = prod_s[XLEN-1:0];
        else
            sel = prod_s[PW-1:XLEN];
        fix_res = word_q ? XLEN'($signed(sel[31:0])) : sel;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c) state_nx = special ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // out_valid rises one cycle after DONE is entered and drops on handshake or flush
    always_comb begin
        in_ready_nx  = (state_nx == IDLE);
        busy_nx      = (state_nx != IDLE);
        out_valid_nx = (state == DONE) && (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nx;
            busy      <= busy_nx;
            out_valid <= out_valid_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (accept_c) begin
            op_q    <= op;
            word_q  <= word_c;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            cnt_q   <= word_c ? CW'(32) : CW'(XLEN);
            acc_q   <= '0;
            mcand_q <= PW'(abs_a);
            mplr_q  <= abs_b;
            rem_q   <= '0;
            // Word dividends sit in the top half so the shift-out order matches 32 iterations
            quo_q   <= word_c ? (abs_a << (XLEN - 32)) : abs_a;
            dvsr_q  <= abs_b;
            if (special) result <= special_res;
        end else if (state == CALC) begin
            cnt_q <= cnt_q - CW'(1);
            if (op_q[2]) begin
                rem_q <= rem_nx;
                quo_q <= {quo_q[XLEN-2:0], div_bit};
            end else begin
                if (mplr_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
            end
        end else if (state == FIXUP) begin
            result <= fix_res;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk, rst, flush, in_valid, in_ready, word, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [63:0] op1, op2, result;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    mul_div_unit #(.XLEN(64), .ENABLE_WORD(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model built directly from the RISC-V M-extension rules
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, p;
        logic [127:0]        ua, ub, up;
        int                  sa32, sb32;
        int unsigned         ua32, ub32;
        logic [31:0]         r32;
        longint              sa64, sb64;
        logic [63:0]         r;
        r = '0;
        if (w) begin
            ua32 = a[31:0]; ub32 = b[31:0];
            sa32 = a[31:0]; sb32 = b[31:0];
            if (f == F_DIV) begin
                if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                else r32 = 32'(sa32 / sb32);
            end else if (f == F_DIVU) begin
                if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                else r32 = ua32 / ub32;
            end else if (f == F_REM) begin
                if (ub32 == 0) r32 = ua32;
                else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
                else r32 = 32'(sa32 % sb32);
            end else if (f == F_REMU) begin
                if (ub32 == 0) r32 = ua32;
                else r32 = ua32 % ub32;
            end else begin
                r32 = ua32 * ub32;
            end
            r = {{32{r32[31]}}, r32};
        end else begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            ua = {64'd0, a};
            ub = {64'd0, b};
            sa64 = a;
            sb64 = b;
            case (f)
                3'd0: begin up = ua * ub; r = up[63:0]; end
                3'd1: begin p = sa * sb; r = p[127:64]; end
                3'd2: begin p = sa * $signed(ub); r = p[127:64]; end
                3'd3: begin up = ua * ub; r = up[127:64]; end
                3'd4: begin
                    if (b == 0) r = '1;
                    else if (a == MIN64 && b == '1) r = a;
                    else r = 64'(sa64 / sb64);
                end
                3'd5: begin
                    if (b == 0) r = '1;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == MIN64 && b == '1) r = '0;
                    else r = 64'(sa64 % sb64);
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic spec;
        if (w) spec = f[2] && (b[31:0] == 32'd0 ||
                      (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF));
        else   spec = f[2] && (b == 64'd0 || (!f[0] && a == MIN64 && b == '1));
        if (spec) return 1;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = MIN64;
            3:       v = 64'($urandom_range(0, 9));
            4:       v = 64'hFFFF_FFFF_8000_0000;
            5:       v = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic start_op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        op = f; word = w; op1 = a; op2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7)); op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_valid = (lat < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int lat;
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
        start_op(f, w, a, b);
        wait_valid(lat);
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " result"}, result, exp_res);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; word = 1'b0; op1 = '0; op2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset result", result, 64'd0);

        run_op("mul 7*-3", F_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu ones", F_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh ones", F_MULH, 1'b0, '1, '1, 64'd0, 66);
        run_op("div by zero", F_DIV, 1'b0, 64'd1234, 64'd0, '1, 1);
        run_op("rem by zero", F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
        run_op("div overflow", F_DIV, 1'b0, MIN64, '1, MIN64, 1);
        run_op("rem overflow", F_REM, 1'b0, MIN64, '1, 64'd0, 1);
        run_op("divw", F_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("remw", F_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("mulhu word", F_MULHU, 1'b1, 64'h1234_0000_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("divuw zero", F_DIVU, 1'b1, 64'd5, 64'hABCD_0000_0000_0000, '1, 1);
        run_op("remuw zero", F_REMU, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1);

        // Result held while the consumer stalls
        start_op(F_MUL, 1'b1, 64'd5, 64'd6);
        wait_valid(lat);
        check_eq("hold latency", 64'(lat), 64'd34);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold out_valid", 64'(out_valid), 64'd1);
            check_eq("hold result", result, 64'd30);
            check_eq("hold in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        check_eq("handshake in_ready", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        check_eq("post handshake in_ready", 64'(in_ready), 64'd1);
        check_eq("post handshake out_valid", 64'(out_valid), 64'd0);

        // Flush during CALC overrides a simultaneous request
        start_op(F_MUL, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (9) tick();
        check_eq("calc busy", 64'(busy), 64'd1);
        flush = 1'b1; in_valid = 1'b1; op = F_DIV; word = 1'b0; op2 = '0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush busy", 64'(busy), 64'd0);
        check_eq("flush in_ready", 64'(in_ready), 64'd1);
        check_eq("flush out_valid", 64'(out_valid), 64'd0);
        repeat (5) tick();
        check_eq("flush no accept busy", 64'(busy), 64'd0);
        check_eq("flush no accept out_valid", 64'(out_valid), 64'd0);

        // Flush in DONE beats a consumer handshake
        start_op(F_DIVU, 1'b0, 64'd9, 64'd0);
        wait_valid(lat);
        check_eq("done flush pre valid", 64'(out_valid), 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check_eq("done flush out_valid", 64'(out_valid), 64'd0);
        check_eq("done flush busy", 64'(busy), 64'd0);

        // Reset mid-CALC
        start_op(F_DIV, 1'b0, 64'd1000, 64'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst mid out_valid", 64'(out_valid), 64'd0);
        check_eq("rst mid result", result, 64'd0);
        check_eq("rst mid busy", 64'(busy), 64'd0);
        check_eq("rst mid in_ready", 64'(in_ready), 64'd1);
        run_op("after rst", F_DIV, 1'b0, 64'd1000, 64'd7, 64'd142, 66);

        for (int n = 0; n < 80; n++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d op%0d w%0d", n, f, w), f, w, a, b,
                   ref_model(f, w, a, b), ref_latency(f, w, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
